// File: rtl/text_cell_fetch.sv
// Character-cell fetch engine: maps HDMI pixel counters to character/attribute RAM reads
// and realigns the returned data with the counters, adding a frame-latched scroll and a blinking cursor.
module text_cell_fetch #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int BUF_ROWS     = 64,
    parameter int STRIDE       = 128,
    parameter int ADDR_W       = 13,
    parameter int RAM_LATENCY  = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [9:0]        cx,
    input  logic [9:0]        cy,
    input  logic [7:0]        row_offset,
    input  logic              cursor_enable,
    input  logic [7:0]        cursor_col,
    input  logic [7:0]        cursor_row,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_re,
    input  logic [7:0]        ram_char_data,
    input  logic [7:0]        ram_attr_data,
    output logic [7:0]        codepoint,
    output logic [7:0]        attribute,
    output logic [9:0]        cx_out,
    output logic [9:0]        cy_out,
    output logic              active_out
);

    localparam int CHAR_W_LOG = $clog2(CHAR_W);
    localparam int CHAR_H_LOG = $clog2(CHAR_H);
    localparam int BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic       active;
        logic       hit;
        logic [9:0] cx;
        logic [9:0] cy;
    } pix_t;

    logic [7:0]         scroll_q;
    logic [BLINK_W-1:0] blink_cnt;
    logic               cursor_phase;

    logic               in_active;
    logic               in_hit;
    logic               frame_start;
    logic               offset_ok;
    logic [9:0]         scr_row;
    logic [9:0]         col;
    logic [10:0]        row_sum;
    logic [10:0]        buf_row;
    logic [ADDR_W-1:0]  next_address;

    pix_t               s0;
    pix_t               pipe [RAM_LATENCY];
    pix_t               tail;

    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        in_active    = (32'(cx) < SCREEN_W) && (32'(cy) < SCREEN_H);
        scr_row      = cy >> CHAR_H_LOG;
        col          = cx >> CHAR_W_LOG;
        row_sum      = {1'b0, scr_row} + {3'b000, scroll_q};
        buf_row      = row_sum;
        if (32'(row_sum) >= BUF_ROWS) begin
            buf_row = row_sum - 11'(BUF_ROWS);
        end
        next_address = ADDR_W'(32'(buf_row) * 32'(STRIDE) + 32'(col));
        in_hit       = cursor_enable && cursor_phase && in_active
                       && (col == {2'b00, cursor_col}) && (scr_row == {2'b00, cursor_row});
        frame_start  = (cx == 10'd0) && (cy == 10'd0);
        offset_ok    = 32'(row_offset) < BUF_ROWS;
    end

    // Scroll and blink state only move at frame start, so a frame never tears.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            scroll_q     <= 8'd0;
            blink_cnt    <= '0;
            cursor_phase <= 1'b1;
        end else if (frame_start) begin
            if (offset_ok) begin
                scroll_q <= row_offset;
            end
            if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
                blink_cnt    <= '0;
                cursor_phase <= ~cursor_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            s0          <= '0;
            ram_address <= '0;
            ram_re      <= 1'b0;
        end else begin
            s0.active <= in_active;
            s0.hit    <= in_hit;
            s0.cx     <= cx;
            s0.cy     <= cy;
            ram_re    <= in_active;
            if (in_active) begin
                ram_address <= next_address;
            end
        end
    end

    // NOTE: this delay line is a handful of flops, not a RAM, so it is reset to flush stale pixels.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[RAM_LATENCY-1];

    // RAM data arrives together with the tail of the delay line; capture both into the outputs.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            codepoint  <= 8'h00;
            attribute  <= 8'h00;
            cx_out     <= 10'd0;
            cy_out     <= 10'd0;
            active_out <= 1'b0;
        end else begin
            cx_out     <= tail.cx;
            cy_out     <= tail.cy;
            active_out <= tail.active;
            if (!tail.active) begin
                codepoint <= 8'h00;
                attribute <= 8'h00;
            end else begin
                codepoint <= ram_char_data;
                attribute <= tail.hit ? {ram_attr_data[3:0], ram_attr_data[7:4]} : ram_attr_data;
            end
        end
    end

endmodule

// File: tb/tb_text_cell_fetch.sv
// Directed bench for text_cell_fetch at RAM latency 1 and 3, checked by a reference model
// whose expected outputs are queued at drive time and popped when the DUT output is due.
module tb_text_cell_fetch;

    typedef struct packed {
        logic       active;
        logic [9:0] cx;
        logic [9:0] cy;
        logic [7:0] cp;
        logic [7:0] attr;
    } exp_t;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic [9:0]  cx, cy;
    logic [7:0]  row_offset;
    logic        cursor_enable;
    logic [7:0]  cursor_col, cursor_row;

    logic [12:0] a1_address, a3_address;
    logic        a1_re, a3_re;
    logic [7:0]  r1_char, r1_attr, r3_char, r3_attr;
    logic [7:0]  cp1, at1, cp3, at3;
    logic [9:0]  cxo1, cyo1, cxo3, cyo3;
    logic        act1, act3;

    int compared   = 0;
    int mismatched = 0;

    exp_t q1[$];
    exp_t q3[$];

    int          m_scroll;
    int          m_blink;
    bit          m_phase;
    logic [12:0] m_addr;
    logic        exp_re;
    bit          prev_rst = 0;
    bit          prev_drv = 0;

    always #5 clk_pixel = ~clk_pixel;

    text_cell_fetch #(.RAM_LATENCY(1)) u_dut1 (
        .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy), .row_offset(row_offset),
        .cursor_enable(cursor_enable), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .ram_address(a1_address), .ram_re(a1_re), .ram_char_data(r1_char), .ram_attr_data(r1_attr),
        .codepoint(cp1), .attribute(at1), .cx_out(cxo1), .cy_out(cyo1), .active_out(act1)
    );

    text_cell_fetch #(.RAM_LATENCY(3)) u_dut3 (
        .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy), .row_offset(row_offset),
        .cursor_enable(cursor_enable), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .ram_address(a3_address), .ram_re(a3_re), .ram_char_data(r3_char), .ram_attr_data(r3_attr),
        .codepoint(cp3), .attribute(at3), .cx_out(cxo3), .cy_out(cyo3), .active_out(act3)
    );

    // RAM contents: buffer row 2 holds 'A' with attribute 0x1F, everything else is address-derived.
    function automatic logic [15:0] ram_word(input logic [12:0] a);
        if (a[12:7] == 6'd2) return {8'h41, 8'h1F};
        return {a[7:0] ^ 8'h5A, a[12:8], 3'b101};
    endfunction

    logic [15:0] r1_q, r3_q;
    logic [12:0] r3_a0, r3_a1;

    always @(posedge clk_pixel) begin
        r1_q  <= ram_word(a1_address);
        r3_a0 <= a3_address;
        r3_a1 <= r3_a0;
        r3_q  <= ram_word(r3_a1);
    end

    assign r1_char = r1_q[15:8];
    assign r1_attr = r1_q[7:0];
    assign r3_char = r3_q[15:8];
    assign r3_attr = r3_q[7:0];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pixel clock: check what the DUTs produced, then drive the next pixel and queue its expectation.
    task automatic step(input logic rst, input logic [9:0] x, input logic [9:0] y);
        exp_t        e;
        int          xi, yi, srow, colv, brow;
        logic        act, hit;
        logic [15:0] w;
        @(negedge clk_pixel);
        if (prev_rst) begin
            check("reset_zero_l1", {a1_re, a1_address, cp1, at1, cxo1, cyo1, act1}, 64'd0);
            check("reset_zero_l3", {a3_re, a3_address, cp3, at3, cxo3, cyo3, act3}, 64'd0);
        end else if (prev_drv) begin
            check("ram_re_l1", 64'(a1_re), 64'(exp_re));
            check("ram_address_l1", 64'(a1_address), 64'(m_addr));
            check("ram_re_l3", 64'(a3_re), 64'(exp_re));
            check("ram_address_l3", 64'(a3_address), 64'(m_addr));
        end
        if (q1.size() == 3) begin
            e = q1.pop_front();
            check("aligned_l1", 64'({act1, cxo1, cyo1, cp1, at1}), 64'(e));
        end
        if (q3.size() == 5) begin
            e = q3.pop_front();
            check("aligned_l3", 64'({act3, cxo3, cyo3, cp3, at3}), 64'(e));
        end

        reset = rst;
        cx    = x;
        cy    = y;
        if (rst) begin
            if (!prev_rst) begin
                q1.delete();
                q3.delete();
            end
            m_scroll = 0;
            m_blink  = 0;
            m_phase  = 1'b1;
            m_addr   = '0;
            exp_re   = 1'b0;
            q1.push_back('0);
            q3.push_back('0);
        end else begin
            xi   = int'(x);
            yi   = int'(y);
            act  = (xi < 640) && (yi < 480);
            srow = yi / 16;
            colv = xi / 8;
            brow = srow + m_scroll;
            if (brow >= 64) brow = brow - 64;
            if (act) m_addr = 13'(brow * 128 + colv);
            exp_re = act;
            hit = cursor_enable && m_phase && act
                  && (colv == int'(cursor_col)) && (srow == int'(cursor_row));
            w = ram_word(m_addr);
            e.active = act;
            e.cx     = x;
            e.cy     = y;
            e.cp     = act ? w[15:8] : 8'h00;
            e.attr   = !act ? 8'h00 : (hit ? {w[3:0], w[7:4]} : w[7:0]);
            q1.push_back(e);
            q3.push_back(e);
            if (xi == 0 && yi == 0) begin
                if (int'(row_offset) < 64) m_scroll = int'(row_offset);
                if (m_blink == 29) begin
                    m_blink = 0;
                    m_phase = ~m_phase;
                end else begin
                    m_blink++;
                end
            end
        end
        prev_rst = rst;
        prev_drv = !rst;
    endtask

    // Holding a pixel long enough lets both latencies show it on their outputs.
    task automatic hold(input logic [9:0] x, input logic [9:0] y);
        repeat (6) step(1'b0, x, y);
    endtask

    initial begin
        reset         = 1'b1;
        cx            = 10'd0;
        cy            = 10'd0;
        row_offset    = 8'd0;
        cursor_enable = 1'b0;
        cursor_col    = 8'd4;
        cursor_row    = 8'd2;

        // Reset held mid-line, then the first active pixel.
        repeat (3) step(1'b1, 10'd100, 10'd50);
        hold(10'd17, 10'd35);
        check("t2_addr", 64'(a1_address), 64'd258);
        check("t2_re", 64'(a1_re), 64'd1);
        check("t2_out_l1", 64'({act1, cxo1, cyo1, cp1, at1}), 64'({1'b1, 10'd17, 10'd35, 8'h41, 8'h1F}));
        check("t2_out_l3", 64'({act3, cxo3, cyo3, cp3, at3}), 64'({1'b1, 10'd17, 10'd35, 8'h41, 8'h1F}));

        // Horizontal then vertical blanking.
        hold(10'd700, 10'd35);
        check("t5_re", 64'(a1_re), 64'd0);
        check("t5_addr_hold", 64'(a1_address), 64'd258);
        check("t5_out_l3", 64'({act3, cp3, at3}), 64'd0);
        for (int x = 8; x < 48; x += 3) step(1'b0, 10'(x), 10'd35);
        hold(10'd10, 10'd500);
        check("t5_vblank_out_l1", 64'({act1, cp1, at1}), 64'd0);

        // Scroll wrap around the ring buffer and rejection of out-of-range offsets.
        row_offset = 8'd40;
        step(1'b0, 10'd0, 10'd0);
        hold(10'd24, 10'd464);
        check("t3_wrap_addr", 64'(a3_address), 64'd643);
        row_offset = 8'd70;
        step(1'b0, 10'd0, 10'd0);
        hold(10'd24, 10'd464);
        check("t3_bad_offset_addr", 64'(a1_address), 64'd643);
        row_offset = 8'd63;
        step(1'b0, 10'd0, 10'd0);
        hold(10'd8, 10'd464);
        check("t3_offset63_addr", 64'(a1_address), 64'd3585);
        for (int y = 0; y < 480; y += 37) step(1'b0, 10'd8, 10'(y));

        // Mid-frame offset change waits for the next frame start.
        row_offset = 8'd0;
        step(1'b0, 10'd0, 10'd0);
        hold(10'd16, 10'd100);
        check("t4_before_addr", 64'(a1_address), 64'd770);
        row_offset = 8'd3;
        hold(10'd16, 10'd200);
        check("t4_midframe_addr", 64'(a1_address), 64'd1538);
        step(1'b0, 10'd0, 10'd0);
        hold(10'd16, 10'd100);
        check("t4_next_frame_addr", 64'(a1_address), 64'd1154);

        // Reset mid-frame, then the first frame start latches normally.
        row_offset = 8'd7;
        hold(10'd300, 10'd200);
        repeat (3) step(1'b1, 10'd300, 10'd200);
        hold(10'd8, 10'd48);
        check("t1_post_reset_addr", 64'(a1_address), 64'd385);
        step(1'b0, 10'd0, 10'd0);
        hold(10'd8, 10'd48);
        check("t1_latched_addr", 64'(a3_address), 64'd1281);

        // Cursor blink over 60 frame starts, with the cursor disabled for a few frames.
        row_offset = 8'd0;
        repeat (2) step(1'b1, 10'd0, 10'd0);
        cursor_enable = 1'b1;
        hold(10'd36, 10'd40);
        check("t6_pre_frame_l1", 64'(at1), 64'hF1);
        for (int k = 1; k <= 60; k++) begin
            step(1'b0, 10'd0, 10'd0);
            cursor_enable = (k >= 10 && k <= 14) ? 1'b0 : 1'b1;
            step(1'b0, 10'(32 + (k % 8)), 10'(32 + (k % 16)));
            step(1'b0, 10'd31, 10'd40);
            step(1'b0, 10'd40, 10'd40);
            step(1'b0, 10'd36, 10'd31);
            step(1'b0, 10'd36, 10'd48);
            if (k == 1 || k == 29 || k == 30 || k == 59 || k == 60) begin
                hold(10'd36, 10'd40);
                check("t6_blink_attr_l1", 64'(at1), (k >= 30 && k < 60) ? 64'h1F : 64'hF1);
                check("t6_blink_attr_l3", 64'(at3), (k >= 30 && k < 60) ? 64'h1F : 64'hF1);
                check("t6_blink_cp_l3", 64'(cp3), 64'h41);
            end
        end
        repeat (6) step(1'b0, 10'd650, 10'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/text_cell_fetch.md
Name: text_cell_fetch

Overview:
- Parametrised character-cell fetch engine for the text console path.
- Converts the HDMI core's pixel counters into character/attribute RAM addresses and read enables.
- Pipelines the returned data so it is aligned with the counters it was fetched for.
- Adds a tear-free scroll offset latched at frame start and a blinking hardware cursor. It sits between the hdmi core (cx/cy), the dual character/attribute RAMs, and the console renderer.

Parameters:
- SCREEN_W, 640, active pixels per line
- SCREEN_H, 480, active lines per frame
- CHAR_W, 8, cell width in pixels (power of two)
- CHAR_H, 16, cell height in pixels (power of two)
- BUF_ROWS, 64, rows held in the RAM ring buffer (may be any value ≥ SCREEN_H/CHAR_H)
- STRIDE, 128, RAM words per buffer row (≥ SCREEN_W/CHAR_W)
- ADDR_W, 13, RAM address width (must hold BUF_ROWS*STRIDE-1)
- RAM_LATENCY, 1, clocks from ram_re/ram_address to valid ram data (1..4)
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  synchronous, active-high
- cx  in  10  current pixel x from hdmi core
- cy  in  10  current pixel y from hdmi core
- row_offset  in  8  scroll offset in buffer rows
- cursor_enable  in  1  cursor on
- cursor_col  in  8  cursor cell column
- cursor_row  in  8  cursor cell row (screen-relative)
- ram_address  out  ADDR_W  RAM word address
- ram_re  out  1  RAM read enable (char and attr)
- ram_char_data  in  8  codepoint from RAM
- ram_attr_data  in  8  attribute from RAM
- codepoint  out  8  aligned codepoint to console
- attribute  out  8  aligned attribute to console
- cx_out  out  10  cx delayed to match codepoint
- cy_out  out  10  cy delayed to match codepoint
- active_out  out  1  aligned active-area flag

Behaviour:
- Single clock, clk_pixel; reset is synchronous and active-high. Every output is 0 on the cycle after reset is sampled high.
- Internal state cleared by reset:
  - scroll_q = 0, blink_cnt = 0, cursor_phase = 1 (visible).
  - Pipeline valid bits cleared.
- Stage 0 (registered, cycle t+1):
  - active = (cx < SCREEN_W) && (cy < SCREEN_H).
  - scr_row = cy / CHAR_H; col = cx / CHAR_W.
  - buf_row = scr_row + scroll_q; if buf_row ≥ BUF_ROWS, subtract BUF_ROWS (single subtraction is sufficient because scroll_q < BUF_ROWS).
  - ram_address = buf_row*STRIDE + col, truncated to ADDR_W; ram_re = active.
  - When not active, ram_address holds its previous value and ram_re = 0.
- Data capture: ram data is registered RAM_LATENCY cycles after the address is issued. Total latency from cx/cy to codepoint/attribute/cx_out/cy_out/active_out is RAM_LATENCY+2 cycles, fixed for every pixel.
- cx, cy, active and the cursor-hit flag travel through a matching shift pipeline.
- When the delayed active flag is 0, codepoint and attribute are forced to 0x00.
- Scroll latch: at frame start (cx==0 && cy==0, sampled in stage 0), scroll_q <= row_offset if row_offset < BUF_ROWS; otherwise scroll_q keeps its old value. row_offset changes mid-frame have no effect until the next frame start.
- Cursor:
  - At each frame start, blink_cnt increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and cursor_phase toggles.
  - hit = cursor_enable && cursor_phase && active && col==cursor_col && scr_row==cursor_row. The comparison uses the screen row, not the buffer row.
  - On an aligned hit, attribute is emitted with nibbles swapped ({attr[3:0], attr[7:4]}), i.e. foreground/background inverted for the whole cell. codepoint is unchanged.
- cursor_enable low forces hit=0 but does not stop blink_cnt.
- Reset mid-frame: pipeline flushes; the first frame start after reset latches row_offset normally.
- Simultaneous frame start and cursor wrap/scroll latch: both update on the same clock.

Test Plan:
1. Reset held 3 cycles mid-line, then released → all outputs 0 during reset; the first valid codepoint appears RAM_LATENCY+2 cycles after the first active cx/cy.
2. row_offset=0, cx=17, cy=35 → ram_address = 2*128+2 = 258, ram_re=1. With RAM returning 0x41/0x1F, codepoint=0x41 and attribute=0x1F on cx_out=17, cy_out=35, active_out=1.
3. row_offset=40, BUF_ROWS=64, cy=29*16 → buf_row = 69-64 = 5, ram_address = 5*128 + col. Then row_offset=70 → scroll_q stays 40.
4. row_offset changed from 0 to 3 at cy=100 → address rows are unchanged until cx=0,cy=0; rows are offset by 3 from the next frame.
5. cx=700 (blanking) → ram_re=0 and aligned codepoint/attribute=0x00, active_out=0.
6. cursor_enable=1, col 4, row 2, attr 0x1F → cells at cx 32..39, cy 32..47 emit attribute 0xF1 for 30 frames, then 0x1F for 30 frames, repeating; RAM_LATENCY=3 gives the same results with latency 5.
